// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;
    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int MEM_TIMEOUT_DEF = 64;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs from ID/EX/MEM and pipeline-register controls.
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_ex_mem_read;
    logic [4:0]       id_ex_rt;
    logic             branch_taken;
    logic             ex_mem_mem_req;
    logic             dmem_ready;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_mem_hold;
    logic             mem_wb_bubble;
    logic             dmem_valid;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;
    modport master (
        output id_rs, id_rt, id_uses_rt, id_ex_mem_read, id_ex_rt, branch_taken, ex_mem_mem_req, dmem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold, mem_wb_bubble, dmem_valid, mem_err, stall_cycles
    );
    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_ex_mem_read, id_ex_rt, branch_taken, ex_mem_mem_req, dmem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold, mem_wb_bubble, dmem_valid, mem_err, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: up-counter with synchronous clear that stops at a programmable maximum.
module sat_counter #(parameter int W = 8) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] max,
    output logic [W-1:0] count,
    output logic         at_max
);
    assign at_max = count == max;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count <= '0;
        else count <= clr ? '0 : (inc && !at_max) ? count + W'(1) : count;
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer resolving load-use, taken-branch and data-memory waits.
module pipeline_hazard_ctrl import pipe_ctrl_pkg::*; #(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = 16
) (
    input logic                 clk,
    input logic                 rst,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    state_t            state;
    logic              in_wait;
    logic              load_use;
    logic              mem_stall;
    logic              err_q;
    logic              wait_at_max;
    logic              stall_at_max;
    logic [WAIT_W-1:0] wait_cnt;
    assign in_wait  = state == MEM_WAIT;
    assign load_use = bus.id_ex_mem_read && bus.id_ex_rt != REG_ZERO &&
                      (bus.id_ex_rt == bus.id_rs || (bus.id_uses_rt && bus.id_ex_rt == bus.id_rt));
    // A held request in MEM_WAIT keeps dmem_valid up, so one term covers both freeze cases.
    assign bus.dmem_valid    = rst && (in_wait || bus.ex_mem_mem_req);
    assign mem_stall         = bus.dmem_valid && !bus.dmem_ready;
    assign bus.pc_write      = rst && !mem_stall && !load_use;
    assign bus.if_id_write   = bus.pc_write;
    assign bus.if_id_flush   = rst && !mem_stall && !load_use && bus.branch_taken;
    assign bus.id_ex_bubble  = !rst || (!mem_stall && load_use);
    assign bus.ex_mem_hold   = mem_stall;
    assign bus.mem_wb_bubble = !rst || mem_stall;
    assign bus.mem_err       = err_q || wait_at_max;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            err_q <= 1'b0;
        end else begin
            state <= mem_stall ? MEM_WAIT : RUN;
            err_q <= err_q || wait_at_max;
        end
    end
    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (in_wait),
        .clr    (!in_wait && mem_stall),
        .max    (WAIT_W'(MEM_TIMEOUT)),
        .count  (wait_cnt),
        .at_max (wait_at_max)
    );
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (!bus.pc_write && !stall_at_max),
        .clr    (1'b0),
        .max    ({CNT_W{1'b1}}),
        .count  (bus.stall_cycles),
        .at_max (stall_at_max)
    );
endmodule
